// File: rtl/gate_pkg.sv
// Shared constants for the gate unit: op encodings and output queue depth.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  localparam int QDEPTH = 2;

endpackage

// File: rtl/gate_bitwise.sv
// Purely combinational eight-way bitwise gate; also serves as a golden model
// for the gate benches. Operand b is ignored for NOT and BUF.
module gate_bitwise
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] f
);

  // Op decode.
  always_comb begin
    f = '0;
    case (op)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_NAND: f = ~(a & b);
      OP_NOR:  f = ~(a | b);
      OP_XOR:  f = a ^ b;
      OP_XNOR: f = ~(a ^ b);
      OP_NOT:  f = ~a;
      OP_BUF:  f = a;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit_pipe.sv
// Registered bitwise gate unit. Results (not operands) are written into a
// 2-entry queue with valid/ready on both sides; res_cnt counts consumed results.
module gate_unit_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic             y_all,
  output logic [CNT_W-1:0] res_cnt
);

  localparam logic [1:0] FULL = 2'(QDEPTH);

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             head;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic             tail;

  gate_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .a  (a),
    .b  (b),
    .op (op),
    .f  (f)
  );

  // in_ready looks only at registered occupancy, never at out_ready.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Write slot: head when empty, the other slot when one entry is held.
  assign tail = head ^ count[0];

  // Result storage; only a push writes, so op/a/b are don't-care otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
    end else if (push) begin
      if (tail) data1 <= f;
      else      data0 <= f;
    end
  end

  // Head pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Consumed-result counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_cnt <= '0;
    else if (pop) res_cnt <= res_cnt + CNT_W'(1);
  end

  // Empty queue forces y to zero so stale entries never show.
  assign y     = out_valid ? (head ? data1 : data0) : '0;
  assign y_any = |y;
  assign y_all = out_valid & (&y);

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Directed bench for gate_unit_pipe: a WIDTH=2 instance for the truth table and
// a WIDTH=8, CNT_W=3 instance for backpressure, streaming, reductions, reset and wrap.
module tb_gate_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic       v2, ir2, ov2, or2, any2, all2;
  logic [1:0] a2, b2, y2;
  logic [2:0] op2;
  logic [7:0] cnt2;

  logic       v8, ir8, ov8, or8, any8, all8;
  logic [7:0] a8, b8, y8;
  logic [2:0] op8;
  logic [2:0] cnt8;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] lut [8];
  logic [1:0] e2;
  logic [7:0] e8;

  always #5 clk = ~clk;

  gate_unit_pipe #(.WIDTH(2), .CNT_W(8)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .a(a2), .b(b2),
    .op(op2), .out_valid(ov2), .out_ready(or2), .y(y2), .y_any(any2),
    .y_all(all2), .res_cnt(cnt2)
  );

  gate_unit_pipe #(.WIDTH(8), .CNT_W(3)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .op(op8), .out_valid(ov8), .out_ready(or8), .y(y8), .y_any(any8),
    .y_all(all8), .res_cnt(cnt8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // Per-op truth tables indexed by {a_bit, b_bit}.
    lut[0] = 4'b1000; lut[1] = 4'b1110; lut[2] = 4'b0111; lut[3] = 4'b0001;
    lut[4] = 4'b0110; lut[5] = 4'b1001; lut[6] = 4'b0011; lut[7] = 4'b1100;

    rst_n = 1'b0;
    v2 = 0; a2 = 0; b2 = 0; op2 = 0; or2 = 0;
    v8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 0;
    #12;
    check("rst_ov8", 64'(ov8), 64'd0);
    check("rst_ir8", 64'(ir8), 64'd1);
    check("rst_y8", 64'(y8), 64'd0);
    check("rst_any8", 64'(any8), 64'd0);
    check("rst_all8", 64'(all8), 64'd0);
    check("rst_cnt8", 64'(cnt8), 64'd0);
    check("rst_ov2", 64'(ov2), 64'd0);
    rst_n = 1'b1;

    // Truth table sweep, WIDTH=2, streaming one result per cycle.
    or2 = 1;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 16; i++) begin
        v2 = 1; op2 = 3'(o); a2 = 2'(i >> 2); b2 = 2'(i);
        e2[0] = lut[o][{a2[0], b2[0]}];
        e2[1] = lut[o][{a2[1], b2[1]}];
        tick();
        check("tt_ov", 64'(ov2), 64'd1);
        check($sformatf("tt_y op%0d a%0d b%0d", o, a2, b2), 64'(y2), 64'(e2));
        check("tt_any", 64'(any2), 64'(|e2));
        check("tt_all", 64'(all2), 64'(&e2));
      end
    end
    v2 = 0;
    tick();
    check("tt_drain_ov", 64'(ov2), 64'd0);
    check("tt_cnt", 64'(cnt2), 64'd128);
    or2 = 0;

    // Spot value from the hand table: NAND 11,01 -> 10.
    v2 = 1; op2 = 3'd2; a2 = 2'b11; b2 = 2'b01;
    tick();
    v2 = 0;
    check("nand_example", 64'(y2), 64'h2);

    // Backpressure, WIDTH=8.
    or8 = 0;
    v8 = 1; op8 = 3'd0; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    check("bp_y1", 64'(y8), 64'h30);
    check("bp_ir1", 64'(ir8), 64'd1);
    op8 = 3'd4;
    tick();
    check("bp_ir_full", 64'(ir8), 64'd0);
    check("bp_hold_y", 64'(y8), 64'h30);
    op8 = 3'd1; a8 = 8'h0F;
    tick();
    check("bp_blocked_ir", 64'(ir8), 64'd0);
    check("bp_blocked_y", 64'(y8), 64'h30);
    v8 = 0;
    or8 = 1;
    tick();
    check("bp_y2", 64'(y8), 64'hCC);
    check("bp_ir_after_pop", 64'(ir8), 64'd1);
    check("bp_cnt1", 64'(cnt8), 64'd1);
    tick();
    check("bp_empty_ov", 64'(ov8), 64'd0);
    check("bp_empty_y", 64'(y8), 64'h00);
    check("bp_cnt2", 64'(cnt8), 64'd2);
    or8 = 0;

    // Reductions.
    v8 = 1; op8 = 3'd7; a8 = 8'hFF; b8 = 8'h00;
    tick();
    v8 = 0;
    check("red_buf_all", 64'(all8), 64'd1);
    check("red_buf_any", 64'(any8), 64'd1);
    or8 = 1;
    tick();
    check("red_empty_all", 64'(all8), 64'd0);
    check("red_empty_cnt", 64'(cnt8), 64'd3);
    or8 = 0;
    v8 = 1; op8 = 3'd0; a8 = 8'hFF; b8 = 8'h00;
    tick();
    v8 = 0;
    check("red_and_ov", 64'(ov8), 64'd1);
    check("red_and_any", 64'(any8), 64'd0);
    check("red_and_all", 64'(all8), 64'd0);
    or8 = 1;
    tick();
    check("red_and_cnt", 64'(cnt8), 64'd4);

    // Steady stream: 10 XOR ops with 8'h55, one result per cycle.
    or8 = 1;
    for (int i = 0; i < 10; i++) begin
      v8 = 1; op8 = 3'd4; a8 = 8'(i * 17); b8 = 8'h55;
      e8 = 8'(i * 17) ^ 8'h55;
      tick();
      check("st_ov", 64'(ov8), 64'd1);
      check("st_ir", 64'(ir8), 64'd1);
      check($sformatf("st_y%0d", i), 64'(y8), 64'(e8));
    end
    v8 = 0;
    tick();
    check("st_drain_ov", 64'(ov8), 64'd0);
    check("st_cnt", 64'(cnt8), 64'd6);

    // Reset mid-operation with a full queue.
    or8 = 0;
    v8 = 1; op8 = 3'd1; a8 = 8'h01; b8 = 8'h02;
    tick();
    a8 = 8'h04; b8 = 8'h08;
    tick();
    v8 = 0;
    check("mr_full_ir", 64'(ir8), 64'd0);
    check("mr_full_y", 64'(y8), 64'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ov", 64'(ov8), 64'd0);
    check("mr_ir", 64'(ir8), 64'd1);
    check("mr_cnt", 64'(cnt8), 64'd0);
    check("mr_y", 64'(y8), 64'd0);
    rst_n = 1'b1;
    or8 = 1;
    tick();
    check("mr_no_stale1", 64'(ov8), 64'd0);
    tick();
    check("mr_no_stale2", 64'(ov8), 64'd0);
    check("mr_cnt_after", 64'(cnt8), 64'd0);

    // Counter wrap: 9 pops on the 3-bit counter.
    for (int k = 1; k <= 9; k++) begin
      v8 = 1; op8 = 3'd7; a8 = 8'(k);
      or8 = 0;
      tick();
      v8 = 0;
      or8 = 1;
      tick();
      check($sformatf("wrap_cnt%0d", k), 64'(cnt8), 64'(k % 8));
    end
    or8 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
